zpu_sd_sector_ctrl: RTL and testbench
=====================================

Name: zpu_sd_sector_ctrl

Overview:
- Sequences sector transfers between the ZPU firmware register interface and the HPS virtual SD block interface. It owns the 512-byte sector buffer port B, the LBA register and the mount/status word.
- Sits in the emu top level between the atari core ZPU_OUT2/ZPU_OUT3/ZPU_RD/ZPU_WR/ZPU_IN2/ZPU_IN3 signals, hps_io's sd_* and img_* signals, and the sdbuf dual-port RAM.
- Adds a handshake FSM with a timeout, so that a lost sd_ack cannot hang the firmware.

Parameters:
- ADDR_W, 9, sector buffer address width (2^ADDR_W bytes).
- TMO_W, 24, timeout counter width; a timeout fires when the counter reaches all-ones, which is 2^TMO_W-1 cycles.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_lba_sel  in  1  ZPU_OUT2[0]. Selects LBA/filesize instead of buffer data.
- cmd_blk_rd  in  1  ZPU_OUT2[1]. A rising edge requests a sector read.
- cmd_blk_wr  in  1  ZPU_OUT2[2]. A rising edge requests a sector write.
- zpu_io_wr  in  1  ZPU_WR[5]. A level clears the buffer address.
- zpu_data_wr  in  1  ZPU_WR[6]. Data/LBA write strobe.
- zpu_data_rd  in  1  ZPU_RD[2]. Data read strobe.
- zpu_wdata  in  32  ZPU_OUT3.
- zpu_rdata  out  32  Drives ZPU_IN3.
- zpu_status  out  8  Drives ZPU_IN2: {readonly, filetype[1:0], fileno[2:0], mounted, io_done}.
- tmo_err  out  1  Sticky timeout flag.
- busy  out  1  FSM is not in IDLE.
- sd_lba  out  32  Sector address to hps_io.
- sd_rd  out  1  Read request.
- sd_wr  out  1  Write request.
- sd_ack  in  1  hps_io acknowledge.
- buf_addr  out  ADDR_W  Sector buffer port B address.
- buf_wr  out  1  Sector buffer port B write enable.
- buf_wdata  out  8  Sector buffer port B data, zpu_wdata[7:0].
- buf_q  in  8  Sector buffer port B read data.
- img_mounted  in  1  Mount strobe from hps_io.
- img_size  in  32  Image size, lower 32 bits.
- ioctl_index  in  8  Menu file index.

Behaviour:
- Reset values:
  - sd_rd=0, sd_wr=0, sd_lba=0
  - buf_addr=0, buf_wr=0
  - io_done=1, busy=0, tmo_err=0, FSM=IDLE
  - fileno=0, readonly=1
  - mounted <= |img_size, re-evaluated every reset cycle
  - filetype and filesize are retained across reset
- Reset mid-transfer drops sd_rd/sd_wr in the same cycle.
- Strobe edges:
  - zpu_data_wr passes through two registers. A rising edge is detected on the second stage, so the write takes effect 2 cycles after the strobe rises.
  - cmd_blk_rd, cmd_blk_wr and zpu_data_rd each pass through one register. Cmd edges are rising; data_rd edges are falling.
- Data write edge:
  - cmd_lba_sel=1: sd_lba <= zpu_wdata.
  - Otherwise: buf_wr pulses for exactly 1 cycle with buf_wdata=zpu_wdata[7:0], and buf_addr increments on the following cycle.
- A falling edge of zpu_data_rd increments buf_addr.
- buf_addr wraps from 2^ADDR_W-1 to 0.
- zpu_io_wr=1 forces buf_addr=0. This has priority over any increment in the same cycle.
- zpu_rdata = cmd_lba_sel ? filesize : {24'b0, buf_q}. Combinational.
- FSM states: IDLE, REQ, ACK.
  - IDLE:
    - Rising edge of cmd_blk_rd → REQ, with sd_rd=1, io_done=0, timer=0.
    - Rising edge of cmd_blk_wr → REQ, with sd_wr=1, io_done=0, timer=0.
    - If both edges arrive in the same cycle, read wins and the write edge is dropped.
  - REQ: when sd_ack=1, clear sd_rd/sd_wr and go to ACK.
  - ACK: on the first cycle with sd_ack=0, set io_done=1 and go to IDLE.
  - In REQ or ACK, the timer increments every cycle. At all-ones: clear sd_rd/sd_wr, set io_done=1 and tmo_err=1, go to IDLE.
  - Cmd edges arriving while busy are ignored (not queued).
  - tmo_err is cleared only by reset or by the next accepted command.
- Mount: on a rising edge of img_mounted:
  - fileno=0, filetype=ioctl_index[7:6], readonly=1
  - mounted toggles
  - filesize=img_size
  - Mount events are accepted in any FSM state and do not disturb a transfer.
- busy = (state != IDLE).

Decomposition:
- Package zpu_sd_pkg holds:
  - the state enum (IDLE, REQ, ACK)
  - the status bit index constants (ST_DONE=0, ST_MNT=1, ST_FNO=2..4, ST_FTYPE=5..6, ST_RO=7)
  - the OUT2 bit constants (LBA_SEL=0, BLK_RD=1, BLK_WR=2)
- One sub-module, strobe_edge: a parameterised delay depth plus rise/fall selection, outputting a single-cycle pulse. It is instantiated for data_wr (depth 2), data_rd, blk_rd, blk_wr and img_mounted.

Test Plan:
- Reset with img_size=0x2000 → mounted=1, io_done=1, sd_rd=sd_wr=0, buf_addr=0; zpu_status=0x83.
- cmd_lba_sel=1, data_wr pulse with wdata=0x12345678 → sd_lba=0x12345678 two cycles later, and no buf_wr.
- io_wr, then 3 data_wr pulses with lba_sel=0 and wdata 0xA1, 0xA2, 0xA3 → buf_wr pulses at addresses 0, 1, 2 with those bytes, and final buf_addr=3. Also: buf_addr=511 followed by one data_rd fall → buf_addr=0.
- Rising edge of cmd_blk_rd; sd_ack high for 5 cycles, then low → sd_rd falls in the cycle after ack rises, io_done=0 throughout, io_done=1 one cycle after ack falls, busy=0.
- With TMO_W=4: cmd_blk_wr, no sd_ack → after 15 cycles sd_wr=0, io_done=1, tmo_err=1. A following cmd_blk_rd clears tmo_err.
- cmd_blk_rd and cmd_blk_wr rising together → only sd_rd asserted. While busy, an img_mounted rise with ioctl_index=0x40 → filetype=1, mounted toggles, sd_rd unaffected. A reset in REQ drops sd_rd on the same cycle.

Source files
------------

// File: rtl/zpu_sd_pkg.sv
// Shared types and bit positions for the ZPU virtual-SD sector controller.
// Status word layout and OUT2 command bit positions.
package zpu_sd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK
  } state_e;

  localparam int ST_DONE  = 0;
  localparam int ST_MNT   = 1;
  localparam int ST_FNO   = 2;
  localparam int ST_FTYPE = 5;
  localparam int ST_RO    = 7;

  localparam int LBA_SEL = 0;
  localparam int BLK_RD  = 1;
  localparam int BLK_WR  = 2;

endpackage

// File: rtl/zpu_sd_sector_ctrl_strobe_edge.sv
// Delayed strobe edge detector producing a one-cycle pulse.
// DEPTH registers of delay; RISE selects rising or falling edge.
module strobe_edge #(
  parameter int DEPTH = 1,
  parameter bit RISE  = 1'b1
) (
  input  logic clk_i,
  input  logic sig_i,
  output logic pulse_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH:0]   tap;
  logic             cur;
  logic             prv;

  assign tap = {pipe_q, sig_i};
  assign cur = tap[DEPTH-1];
  assign prv = tap[DEPTH];

  // Left unreset so a strobe held across reset does not fake an edge.
  always_ff @(posedge clk_i) begin
    pipe_q <= tap[DEPTH-1:0];
  end

  assign pulse_o = RISE ? (cur & ~prv) : (~cur & prv);

endmodule

// File: rtl/zpu_sd_sector_ctrl.sv
// Sector transfer sequencer between ZPU registers and HPS virtual SD.
// Owns buffer port B addressing, the LBA register and the status word.
import zpu_sd_pkg::*;

module zpu_sd_sector_ctrl #(
  parameter int ADDR_W = 9,
  parameter int TMO_W  = 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cmd_lba_sel,
  input  logic              cmd_blk_rd,
  input  logic              cmd_blk_wr,
  input  logic              zpu_io_wr,
  input  logic              zpu_data_wr,
  input  logic              zpu_data_rd,
  input  logic [31:0]       zpu_wdata,
  output logic [31:0]       zpu_rdata,
  output logic [7:0]        zpu_status,
  output logic              tmo_err,
  output logic              busy,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_wr,
  output logic [7:0]        buf_wdata,
  input  logic [7:0]        buf_q,
  input  logic              img_mounted,
  input  logic [31:0]       img_size,
  input  logic [7:0]        ioctl_index
);

  logic [2:0] out2;
  logic       lba_sel;
  logic       dwr_p;
  logic       drd_p;
  logic       brd_p;
  logic       bwr_p;
  logic       mnt_p;
  logic       unused_idx;

  assign out2    = {cmd_blk_wr, cmd_blk_rd, cmd_lba_sel};
  assign lba_sel = out2[LBA_SEL];
  assign unused_idx = ^ioctl_index[5:0];

  strobe_edge #(.DEPTH(2), .RISE(1'b1)) u_dwr (
    .clk_i(clk_sys), .sig_i(zpu_data_wr), .pulse_o(dwr_p)
  );
  strobe_edge #(.DEPTH(1), .RISE(1'b0)) u_drd (
    .clk_i(clk_sys), .sig_i(zpu_data_rd), .pulse_o(drd_p)
  );
  strobe_edge #(.DEPTH(1), .RISE(1'b1)) u_brd (
    .clk_i(clk_sys), .sig_i(out2[BLK_RD]), .pulse_o(brd_p)
  );
  strobe_edge #(.DEPTH(1), .RISE(1'b1)) u_bwr (
    .clk_i(clk_sys), .sig_i(out2[BLK_WR]), .pulse_o(bwr_p)
  );
  strobe_edge #(.DEPTH(1), .RISE(1'b1)) u_mnt (
    .clk_i(clk_sys), .sig_i(img_mounted), .pulse_o(mnt_p)
  );

  state_e           state_q, state_d;
  logic             sd_rd_q, sd_rd_d;
  logic             sd_wr_q, sd_wr_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [TMO_W-1:0] timer_inc;
  logic             tmo_hit;

  assign timer_inc = timer_q + TMO_W'(1);
  assign tmo_hit   = &timer_inc;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      sd_rd_q <= 1'b0;
      sd_wr_q <= 1'b0;
      done_q  <= 1'b1;
      tmo_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sd_rd_q <= sd_rd_d;
      sd_wr_q <= sd_wr_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (brd_p || bwr_p) state_d = S_REQ;
      S_REQ: begin
        if (tmo_hit)     state_d = S_IDLE;
        else if (sd_ack) state_d = S_ACK;
      end
      S_ACK: if (tmo_hit || !sd_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sd_rd_d = sd_rd_q;
    sd_wr_d = sd_wr_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    timer_d = timer_q;
    if (state_q == S_IDLE) begin
      // Simultaneous edges: the read is taken, the write is dropped.
      if (brd_p || bwr_p) begin
        sd_rd_d = brd_p;
        sd_wr_d = ~brd_p;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        timer_d = '0;
      end
    end else begin
      timer_d = timer_inc;
      if (tmo_hit) begin
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
        done_d  = 1'b1;
        tmo_d   = 1'b1;
      end else if (state_q == S_REQ && sd_ack) begin
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
      end else if (state_q == S_ACK && !sd_ack) begin
        done_d = 1'b1;
      end
    end
  end

  logic [31:0]       lba_q;
  logic [ADDR_W-1:0] addr_q;
  logic              bwr_q;
  logic              mnt_q;
  logic [2:0]        fno_q;
  logic              ro_q;
  logic [1:0]        ftype_q;
  logic [31:0]       fsize_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lba_q  <= '0;
      addr_q <= '0;
      bwr_q  <= 1'b0;
      mnt_q  <= |img_size;
      fno_q  <= '0;
      ro_q   <= 1'b1;
    end else begin
      bwr_q <= dwr_p & ~lba_sel;
      if (dwr_p && lba_sel) lba_q <= zpu_wdata;
      // The write strobe bumps the address one cycle after buf_wr.
      if (zpu_io_wr) addr_q <= '0;
      else addr_q <= addr_q + ADDR_W'(bwr_q) + ADDR_W'(drd_p);
      if (mnt_p) begin
        mnt_q <= ~mnt_q;
        fno_q <= '0;
        ro_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (mnt_p) begin
      ftype_q <= ioctl_index[7:6];
      fsize_q <= img_size;
    end
  end

  always_comb begin
    zpu_status                 = '0;
    zpu_status[ST_DONE]        = done_q;
    zpu_status[ST_MNT]         = mnt_q;
    zpu_status[ST_FNO +: 3]    = fno_q;
    zpu_status[ST_FTYPE +: 2]  = ftype_q;
    zpu_status[ST_RO]          = ro_q;
  end

  assign zpu_rdata = lba_sel ? fsize_q : {24'b0, buf_q};
  assign tmo_err   = tmo_q;
  assign busy      = (state_q != S_IDLE);
  assign sd_lba    = lba_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign buf_addr  = addr_q;
  assign buf_wr    = bwr_q;
  assign buf_wdata = zpu_wdata[7:0];

endmodule

// File: tb/tb_zpu_sd_sector_ctrl.sv
// Scoreboard bench for zpu_sd_sector_ctrl: directed cases then random ops.
// A monitor pops expected buffer writes, requests and completions.
module tb_zpu_sd_sector_ctrl;

  localparam int AW = 9;
  localparam int TW = 4;
  localparam int NB = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_lba_sel, cmd_blk_rd, cmd_blk_wr;
  logic        zpu_io_wr, zpu_data_wr, zpu_data_rd;
  logic [31:0] zpu_wdata, zpu_rdata;
  logic [7:0]  zpu_status;
  logic        tmo_err, busy;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [AW-1:0] buf_addr;
  logic        buf_wr;
  logic [7:0]  buf_wdata, buf_q;
  logic        img_mounted;
  logic [31:0] img_size;
  logic [7:0]  ioctl_index;

  zpu_sd_sector_ctrl #(.ADDR_W(AW), .TMO_W(TW)) dut (
    .clk_sys(clk), .reset(reset),
    .cmd_lba_sel(cmd_lba_sel), .cmd_blk_rd(cmd_blk_rd),
    .cmd_blk_wr(cmd_blk_wr), .zpu_io_wr(zpu_io_wr),
    .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
    .zpu_wdata(zpu_wdata), .zpu_rdata(zpu_rdata),
    .zpu_status(zpu_status), .tmo_err(tmo_err), .busy(busy),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_wdata(buf_wdata),
    .buf_q(buf_q), .img_mounted(img_mounted), .img_size(img_size),
    .ioctl_index(ioctl_index)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [8:0] a; logic [7:0] d; } wexp_t;
  typedef struct packed { logic wr; logic [31:0] lba; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];
  logic  dq[$];

  // Reference state
  int          m_addr;
  logic [31:0] m_lba;
  logic [31:0] m_fsize;
  logic [1:0]  m_ftype;
  logic        m_mnt;
  logic        m_tmo;

  function automatic logic [7:0] m_status();
    return {1'b1, m_ftype, 3'b000, m_mnt, 1'b1};
  endfunction

  // Monitor
  initial begin
    wexp_t w;
    rexp_t r;
    logic  t;
    logic  p_req, p_busy;
    p_req = 1'b0;
    p_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (buf_wr) begin
        if (wq.size() == 0) chk("buf_wr_unexpected", 1, 0);
        else begin
          w = wq.pop_front();
          chk("buf_wr", {buf_addr, buf_wdata}, {w.a, w.d});
        end
      end
      if ((sd_rd || sd_wr) && !p_req) begin
        if (rq.size() == 0) chk("sd_req_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          chk("sd_req", {sd_rd, sd_wr, sd_lba}, {~r.wr, r.wr, r.lba});
        end
      end
      if (p_busy && !busy) begin
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          t = dq.pop_front();
          chk("done", {io_done_bit(), tmo_err, sd_rd, sd_wr},
              {1'b1, t, 1'b0, 1'b0});
        end
      end
      p_req  = sd_rd | sd_wr;
      p_busy = busy;
    end
  end

  function automatic logic io_done_bit();
    return zpu_status[0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_wr(bit sel, logic [31:0] v);
    cmd_lba_sel = sel;
    zpu_wdata = v;
    zpu_data_wr = 1'b1;
    if (sel) m_lba = v;
    else begin
      wq.push_back(wexp_t'{a: 9'(m_addr), d: v[7:0]});
      m_addr = (m_addr + 1) % NB;
    end
    cyc(1);
    zpu_data_wr = 1'b0;
    cyc(4);
  endtask

  task automatic do_rd();
    zpu_data_rd = 1'b1;
    cyc(1);
    zpu_data_rd = 1'b0;
    cyc(3);
    m_addr = (m_addr + 1) % NB;
  endtask

  task automatic do_iowr();
    zpu_io_wr = 1'b1;
    cyc(1);
    zpu_io_wr = 1'b0;
    cyc(1);
    m_addr = 0;
  endtask

  task automatic do_mount(logic [7:0] idx, logic [31:0] sz);
    ioctl_index = idx;
    img_size = sz;
    img_mounted = 1'b1;
    cyc(1);
    img_mounted = 1'b0;
    cyc(2);
    m_ftype = idx[7:6];
    m_fsize = sz;
    m_mnt = ~m_mnt;
  endtask

  task automatic do_xfer(bit wr, int dly, int hold, bit tmo);
    int n;
    rq.push_back(rexp_t'{wr: wr, lba: m_lba});
    dq.push_back(tmo);
    if (wr) cmd_blk_wr = 1'b1;
    else cmd_blk_rd = 1'b1;
    cyc(1);
    cmd_blk_wr = 1'b0;
    cmd_blk_rd = 1'b0;
    if (!tmo) begin
      cyc(dly);
      sd_ack = 1'b1;
      cyc(hold);
      sd_ack = 1'b0;
      cyc(1);
      chk("xfer_idle", busy, 0);
    end else begin
      n = 0;
      while (busy && n < 40) begin
        cyc(1);
        n++;
      end
      chk("tmo_cycles", n, (1 << TW) - 1);
    end
    m_tmo = tmo;
  endtask

  task automatic check_all();
    logic s;
    s = 1'($urandom_range(0, 1));
    cmd_lba_sel = s;
    buf_q = 8'($urandom);
    #1;
    chk("buf_addr", buf_addr, m_addr);
    chk("sd_lba", sd_lba, m_lba);
    chk("status", zpu_status, m_status());
    chk("tmo_err", tmo_err, m_tmo);
    chk("rdata", zpu_rdata, s ? m_fsize : {24'b0, buf_q});
  endtask

  initial begin
    reset = 1'b1;
    {cmd_lba_sel, cmd_blk_rd, cmd_blk_wr} = '0;
    {zpu_io_wr, zpu_data_wr, zpu_data_rd, sd_ack, img_mounted} = '0;
    zpu_wdata = '0;
    buf_q = '0;
    img_size = 32'h2000;
    ioctl_index = '0;
    m_addr = 0;
    m_lba = '0;
    m_mnt = 1'b0;
    m_tmo = 1'b0;
    cyc(2);
    do_mount(8'h00, 32'h2000);
    cyc(1);
    reset = 1'b0;
    m_mnt = 1'b1;
    cyc(1);
    chk("rst_status", zpu_status, 8'h83);
    chk("rst_sd", {sd_rd, sd_wr, busy, buf_wr, tmo_err}, 0);
    chk("rst_addr", buf_addr, 0);

    // LBA write lands two cycles after the strobe rises
    cmd_lba_sel = 1'b1;
    zpu_wdata = 32'h1234_5678;
    zpu_data_wr = 1'b1;
    @(posedge clk); #1;
    chk("lba_early", sd_lba, 0);
    @(posedge clk); #1;
    chk("lba_write", sd_lba, 32'h1234_5678);
    m_lba = 32'h1234_5678;
    cyc(1);
    zpu_data_wr = 1'b0;
    cyc(3);

    do_iowr();
    do_wr(1'b0, 32'hA1);
    do_wr(1'b0, 32'hA2);
    do_wr(1'b0, 32'hA3);
    chk("addr_after3", buf_addr, 3);
    do_iowr();
    repeat (NB - 1) do_rd();
    chk("addr_511", buf_addr, NB - 1);
    do_rd();
    chk("addr_wrap", buf_addr, 0);

    // Read with acknowledge held for 5 cycles
    rq.push_back(rexp_t'{wr: 1'b0, lba: m_lba});
    dq.push_back(1'b0);
    cmd_blk_rd = 1'b1;
    cyc(1);
    chk("rd_start", {sd_rd, busy, io_done_bit()}, 3'b110);
    cmd_blk_rd = 1'b0;
    sd_ack = 1'b1;
    @(posedge clk); #1;
    chk("rd_drop", sd_rd, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("done_low", io_done_bit(), 0);
    end
    sd_ack = 1'b0;
    @(posedge clk); #1;
    chk("rd_done", {io_done_bit(), busy}, 2'b10);
    cyc(1);

    do_xfer(1'b1, 0, 0, 1'b1);
    check_all();
    do_xfer(1'b0, 2, 2, 1'b0);
    check_all();

    // Both commands together; mount and reset while busy
    rq.push_back(rexp_t'{wr: 1'b0, lba: m_lba});
    dq.push_back(1'b0);
    cmd_blk_rd = 1'b1;
    cmd_blk_wr = 1'b1;
    cyc(1);
    chk("both_cmd", {sd_rd, sd_wr}, 2'b10);
    cmd_blk_rd = 1'b0;
    cmd_blk_wr = 1'b0;
    do_mount(8'h40, 32'h4000);
    chk("mnt_busy", zpu_status, {1'b1, 2'b01, 3'b000, m_mnt, 1'b0});
    chk("mnt_sd_rd", {sd_rd, busy}, 2'b11);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_drop", sd_rd, 0);
    cyc(1);
    reset = 1'b0;
    m_mnt = 1'b1;
    m_addr = 0;
    m_lba = '0;
    m_tmo = 1'b0;
    cyc(1);
    chk("rst_keep", zpu_status, 8'hA3);
    check_all();

    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 6))
        0: do_wr(1'b1, $urandom);
        1, 2: do_wr(1'b0, $urandom);
        3: do_rd();
        4: if ($urandom_range(0, 3) == 0) do_iowr();
           else do_xfer(1'(k & 1), $urandom_range(0, 5),
                        $urandom_range(1, 6), 1'b0);
        5: if ($urandom_range(0, 4) == 0)
             do_xfer(1'($urandom_range(0, 1)), 0, 0, 1'b1);
           else do_mount(8'($urandom), $urandom_range(0, 3) * 32'h1_0000);
        default: do_iowr();
      endcase
      check_all();
    end

    cyc(2);
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
